// File: rtl/ds1302_burstmod_if.sv
// rtl/ds1302_burstmod_if.sv - host-side request/response bundle for the DS1302 transfer engine
interface ds1302_burstmod_if #(
  parameter int LEN_W = 5
);
  logic [1:0]       iCall;
  logic [7:0]       iAddr;
  logic [LEN_W-1:0] iLen;
  logic [7:0]       iData;
  logic             oNext;
  logic [7:0]       oData;
  logic             oValid;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iCall, iAddr, iLen, iData,
    input  oNext, oData, oValid, oBusy, oDone
  );

  modport slave (
    input  iCall, iAddr, iLen, iData,
    output oNext, oData, oValid, oBusy, oDone
  );
endinterface

// File: rtl/ds1302_burstmod.sv
// rtl/ds1302_burstmod.sv - DS1302 3-wire transfer engine; burst length honoured when DS1302_BURST_EN is defined
module ds1302_burstmod #(
  parameter int CLK_DIV  = 25,
  parameter int CE_SETUP = 200,
  parameter int CE_HOLD  = 200,
  parameter int LEN_W    = 5
) (
  input  logic              CLOCK,
  input  logic              RESET,
  ds1302_burstmod_if.slave  host,
  output logic              RTC_NRST,
  output logic              RTC_SCLK,
  inout  wire               RTC_DATA
);
  localparam int BIT_CYC = 2 * CLK_DIV;
  localparam int GAP_MAX = (CE_SETUP > CE_HOLD) ? CE_SETUP : CE_HOLD;
  localparam int CNT_MAX = (GAP_MAX > BIT_CYC) ? GAP_MAX : BIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       sh, sh_n;
  logic [7:0]       data_q, data_n;
  logic             wr, wr_n;
  logic             nrst_q, nrst_n;
  logic             sclk_q, sclk_n;
  logic             oe_q, oe_n;
  logic             next_q, next_n;
  logic             valid_q, valid_n;
  logic             done_q, done_n;
  logic             more;

  wire last_cyc = (cnt == CNT_W'(BIT_CYC - 1));
  wire samp_cyc = (cnt == CNT_W'(CLK_DIV - 1));

`ifdef DS1302_BURST_EN
  logic [LEN_W-1:0] byte_left, byte_n;
  assign more = (byte_left != LEN_W'(1));
  wire unused_bits = ^{host.iAddr[7], host.iAddr[0]};
`else
  assign more = 1'b0;
  wire unused_bits = ^{host.iAddr[7], host.iAddr[0], host.iLen};
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      data_q    <= '0;
      wr        <= 1'b0;
      nrst_q    <= 1'b0;
      sclk_q    <= 1'b0;
      oe_q      <= 1'b0;
      next_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef DS1302_BURST_EN
      byte_left <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      sh        <= sh_n;
      data_q    <= data_n;
      wr        <= wr_n;
      nrst_q    <= nrst_n;
      sclk_q    <= sclk_n;
      oe_q      <= oe_n;
      next_q    <= next_n;
      valid_q   <= valid_n;
      done_q    <= done_n;
`ifdef DS1302_BURST_EN
      byte_left <= byte_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    data_n  = data_q;
    wr_n    = wr;
    nrst_n  = nrst_q;
    sclk_n  = 1'b0;
    oe_n    = oe_q;
    next_n  = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
`ifdef DS1302_BURST_EN
    byte_n  = byte_left;
`endif
    case (state)
      S_IDLE: begin
        nrst_n = 1'b0;
        oe_n   = 1'b0;
        if (host.iCall != 2'b00) begin
          // Write wins when both request bits are set.
          state_n = S_SETUP;
          cnt_n   = '0;
          nrst_n  = 1'b1;
          wr_n    = host.iCall[1];
          sh_n    = {1'b1, host.iAddr[6:1], ~host.iCall[1]};
`ifdef DS1302_BURST_EN
          byte_n  = (host.iLen == '0) ? LEN_W'(1) : host.iLen;
`endif
        end
      end
      S_SETUP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(CE_SETUP - 1)) begin
          state_n = S_CMD;
          cnt_n   = '0;
          bit_n   = '0;
          oe_n    = 1'b1;
        end
      end
      S_CMD: begin
        cnt_n = cnt + 1'b1;
        if (last_cyc) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n = '0;
            if (wr) begin
              state_n = S_WDATA;
              next_n  = 1'b1;
            end else begin
              state_n = S_RDATA;
              oe_n    = 1'b0;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
            sh_n  = {1'b0, sh[7:1]};
          end
        end
      end
      S_WDATA: begin
        cnt_n = cnt + 1'b1;
        if (next_q) sh_n = host.iData;
        if (last_cyc) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n = '0;
            if (more) begin
              next_n = 1'b1;
`ifdef DS1302_BURST_EN
              byte_n = byte_left - 1'b1;
`endif
            end else begin
              state_n = S_HOLD;
              oe_n    = 1'b0;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
            sh_n  = {1'b0, sh[7:1]};
          end
        end
      end
      S_RDATA: begin
        cnt_n = cnt + 1'b1;
        // The chip updates data on SCLK fall, so sample just before the rise.
        if (samp_cyc) begin
          sh_n = {RTC_DATA, sh[7:1]};
          if (bit_idx == 3'd7) begin
            data_n  = {RTC_DATA, sh[7:1]};
            valid_n = 1'b1;
          end
        end
        if (last_cyc) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_n = '0;
            if (more) begin
`ifdef DS1302_BURST_EN
              byte_n = byte_left - 1'b1;
`endif
            end else begin
              state_n = S_HOLD;
            end
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
      S_HOLD: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(CE_HOLD - 1)) begin
          state_n = S_DONE;
          cnt_n   = '0;
          nrst_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    sclk_n = ((state_n == S_CMD) || (state_n == S_WDATA) || (state_n == S_RDATA))
             && (cnt_n >= CNT_W'(CLK_DIV));
  end

  // First cycle of a write byte shows iData directly, before it lands in sh.
  assign RTC_DATA    = oe_q ? (next_q ? host.iData[0] : sh[0]) : 1'bz;
  assign RTC_NRST    = nrst_q;
  assign RTC_SCLK    = sclk_q;
  assign host.oNext  = next_q;
  assign host.oData  = data_q;
  assign host.oValid = valid_q;
  assign host.oDone  = done_q;
  assign host.oBusy  = !RESET && ((state != S_IDLE) || (host.iCall != 2'b00));
endmodule

// File: tb/tb_ds1302_burstmod.sv
// tb/tb_ds1302_burstmod.sv - self-checking bench for ds1302_burstmod with a DS1302 pin-level model
module tb_ds1302_burstmod;
  localparam int CLK_DIV  = 4;
  localparam int CE_SETUP = 8;
  localparam int CE_HOLD  = 8;
  localparam int LEN_W    = 5;
  localparam int BIT_CYC  = 2 * CLK_DIV;
`ifdef DS1302_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rtc_nrst, rtc_sclk;
  wire  rtc_data;
  logic m_drive = 1'b0;
  logic m_bit   = 1'b0;

  pulldown (rtc_data);
  assign rtc_data = m_drive ? m_bit : 1'bz;

  ds1302_burstmod_if #(.LEN_W(LEN_W)) host ();

  ds1302_burstmod #(
    .CLK_DIV (CLK_DIV),
    .CE_SETUP(CE_SETUP),
    .CE_HOLD (CE_HOLD),
    .LEN_W   (LEN_W)
  ) dut (
    .CLOCK   (clk),
    .RESET   (rst),
    .host    (host),
    .RTC_NRST(rtc_nrst),
    .RTC_SCLK(rtc_sclk),
    .RTC_DATA(rtc_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // DS1302 model: latches host bits on SCLK rise, drives read bits from SCLK fall.
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  int         m_bits = 0;
  logic [7:0] m_sh   = 8'h00;
  logic       m_rd   = 1'b0;
  logic       p_sclk = 1'b0;
  logic       p_nrst = 1'b0;

  always @(negedge clk) begin
    int idx, bi;
    if (rtc_nrst && !p_nrst) begin
      m_rx.delete();
      m_bits = 0;
      m_rd   = 1'b0;
    end
    if (!rtc_nrst) begin
      m_drive = 1'b0;
    end else if (rtc_sclk && !p_sclk) begin
      if (m_bits < 8 || !m_rd) begin
        m_sh = {rtc_data, m_sh[7:1]};
        if (m_bits % 8 == 7) begin
          m_rx.push_back(m_sh);
          if (m_bits == 7) m_rd = m_sh[0];
        end
      end
      m_bits++;
    end else if (!rtc_sclk && p_sclk && m_rd && m_bits >= 8) begin
      if (m_bits == 8) check("read_release", rtc_data, 1'b0);
      idx = (m_bits - 8) / 8;
      bi  = (m_bits - 8) % 8;
      if (idx < m_tx.size()) begin
        m_drive = 1'b1;
        m_bit   = m_tx[idx][bi];
      end else begin
        m_drive = 1'b0;
      end
    end
    p_sclk = rtc_sclk;
    p_nrst = rtc_nrst;
  end

  task automatic run_xfer(input string name, input logic [1:0] call, input logic [7:0] addr,
                          input logic [LEN_W-1:0] len, input logic [63:0] bytes,
                          input logic [7:0] exp_cmd, input int exp_n, input int exp_done,
                          input int hold);
    bit         is_wr = call[1];
    int         next_cnt = 0, done_cnt = 0, done_cyc = -1;
    int         first_next = -1, last_next = -1, gap_bad = 0;
    bit         upd = 1'b0;
    logic [7:0] vals[$];
    m_tx.delete();
    for (int i = 0; i < exp_n; i++) m_tx.push_back(bytes[8*i +: 8]);
    @(negedge clk);
    host.iCall = call;
    host.iAddr = addr;
    host.iLen  = len;
    host.iData = bytes[7:0];
    #1;
    check({name, ".busy_accept"}, host.oBusy, 1'b1);
    for (int cyc = 1; cyc < 1200; cyc++) begin
      @(negedge clk);
      if (cyc == hold + 1) host.iCall = 2'b00;
      if (cyc == 1) begin
        check({name, ".nrst_c1"}, rtc_nrst, 1'b1);
        check({name, ".sclk_c1"}, rtc_sclk, 1'b0);
      end
      if (upd) begin
        if (next_cnt < 8) host.iData = bytes[8*next_cnt +: 8];
        upd = 1'b0;
      end
      if (host.oNext) begin
        if (first_next < 0) first_next = cyc;
        else if (cyc - last_next != 8 * BIT_CYC) gap_bad++;
        last_next = cyc;
        next_cnt++;
        upd = 1'b1;
      end
      if (host.oValid) vals.push_back(host.oData);
      if (host.oDone) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check({name, ".busy_done"}, host.oBusy, 1'b1);
          check({name, ".nrst_done"}, rtc_nrst, 1'b0);
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 30) break;
    end
    host.iCall = 2'b00;
    check({name, ".done_cycle"}, done_cyc, exp_done);
    check({name, ".done_count"}, done_cnt, 1);
    check({name, ".next_count"}, next_cnt, is_wr ? exp_n : 0);
    check({name, ".rx_count"}, m_rx.size(), is_wr ? exp_n + 1 : 1);
    if (m_rx.size() > 0) check({name, ".cmd"}, m_rx[0], exp_cmd);
    if (is_wr) begin
      check({name, ".first_next"}, first_next, 1 + CE_SETUP + 8 * BIT_CYC);
      check({name, ".next_gap"}, gap_bad, 0);
      for (int i = 0; i < exp_n && i + 1 < m_rx.size(); i++)
        check($sformatf("%s.wbyte%0d", name, i), m_rx[i+1], bytes[8*i +: 8]);
    end else begin
      check({name, ".valid_count"}, vals.size(), exp_n);
      for (int i = 0; i < exp_n && i < vals.size(); i++)
        check($sformatf("%s.rbyte%0d", name, i), vals[i], bytes[8*i +: 8]);
      check({name, ".odata_last"}, host.oData, bytes[8*(exp_n-1) +: 8]);
    end
  endtask

  typedef struct {
    string            name;
    logic [1:0]       call;
    logic [7:0]       addr;
    logic [LEN_W-1:0] len;
    logic [63:0]      bytes;
    logic [7:0]       cmd;
    int               n;
    int               done;
    int               hold;
  } vec_t;

  vec_t tab[7];

  initial begin
    logic [1:0]       rc;
    logic [7:0]       ra;
    logic [LEN_W-1:0] rl;
    logic [63:0]      rb;
    int               rn, done_seen, valid_seen;

    tab[0] = '{"wr_single",   2'b10, 8'h80, 5'd1, 64'h59,               8'h80, 1, 145, 0};
    tab[1] = '{"rd_single",   2'b01, 8'h80, 5'd1, 64'h23,               8'h81, 1, 145, 0};
    tab[2] = '{"wr_burst8",   2'b10, 8'hBE, 5'd8, 64'h0807060504030201, 8'hBE, 8, 593, 0};
    tab[3] = '{"rd_burst3",   2'b01, 8'hBF, 5'd3, 64'h332211,           8'hBF, 3, 273, 0};
    tab[4] = '{"wr_len0",     2'b10, 8'h05, 5'd0, 64'hC3,               8'h84, 1, 145, 0};
    tab[5] = '{"both_busy",   2'b11, 8'h0D, 5'd1, 64'h7E,               8'h8C, 1, 145, 20};
    tab[6] = '{"rd_burst2",   2'b01, 8'h40, 5'd2, 64'hA55A,             8'hC1, 2, 209, 0};

    host.iCall = 2'b00;
    host.iAddr = 8'h00;
    host.iLen  = '0;
    host.iData = 8'h00;
    repeat (3) @(negedge clk);
    check("reset.nrst",  rtc_nrst,    1'b0);
    check("reset.sclk",  rtc_sclk,    1'b0);
    check("reset.data",  rtc_data,    1'b0);
    check("reset.odata", host.oData,  8'h00);
    check("reset.next",  host.oNext,  1'b0);
    check("reset.valid", host.oValid, 1'b0);
    check("reset.done",  host.oDone,  1'b0);
    check("reset.busy",  host.oBusy,  1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 7; t++)
      run_xfer(tab[t].name, tab[t].call, tab[t].addr, tab[t].len, tab[t].bytes, tab[t].cmd,
               BURST ? tab[t].n : 1, BURST ? tab[t].done : 145, tab[t].hold);

    // Reset in the middle of a write command byte.
    m_tx.delete();
    @(negedge clk);
    host.iCall = 2'b10;
    host.iAddr = 8'hFE;
    host.iLen  = 5'd1;
    host.iData = 8'hA5;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) host.iCall = 2'b00;
    end
    check("rst_mid.pre_nrst", rtc_nrst, 1'b1);
    check("rst_mid.pre_data", rtc_data, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.nrst",  rtc_nrst,   1'b0);
    check("rst_mid.data",  rtc_data,   1'b0);
    check("rst_mid.sclk",  rtc_sclk,   1'b0);
    check("rst_mid.busy",  host.oBusy, 1'b0);
    check("rst_mid.odata", host.oData, 8'h00);
    done_seen  = 0;
    valid_seen = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      done_seen  += int'(host.oDone);
      valid_seen += int'(host.oValid);
    end
    rst = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      done_seen  += int'(host.oDone);
      valid_seen += int'(host.oValid);
    end
    check("rst_mid.no_done",  done_seen,  0);
    check("rst_mid.no_valid", valid_seen, 0);
    run_xfer("after_reset", 2'b10, 8'h80, 5'd1, 64'h3C, 8'h80, 1, 145, 0);

    // Randomized transfers against the arithmetic reference.
    for (int r = 0; r < 6; r++) begin
      rc = 2'($urandom_range(1, 3));
      ra = 8'($urandom);
      rl = LEN_W'($urandom_range(0, 6));
      rb = {32'($urandom), 32'($urandom)};
      rn = BURST ? ((rl == 0) ? 1 : int'(rl)) : 1;
      run_xfer($sformatf("rand%0d", r), rc, ra, rl, rb, {1'b1, ra[6:1], ~rc[1]}, rn,
               1 + CE_SETUP + (8 + 8 * rn) * 2 * CLK_DIV + CE_HOLD, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ds1302_burstmod.md
DS1302_BURSTMOD -- requirements
Module: ds1302_burstmod

Interface
- REQ-001 Parameter CLK_DIV, default 25, sets the number of CLOCK cycles per RTC_SCLK half period (minimum 2).
- REQ-002 Parameter CE_SETUP, default 200, sets the number of CLOCK cycles RTC_NRST is high before the first RTC_SCLK rise.
- REQ-003 Parameter CE_HOLD, default 200, sets the number of CLOCK cycles after the last RTC_SCLK fall before RTC_NRST drops.
- REQ-004 Parameter LEN_W, default 5, sets the width of the burst length field (maximum 2^LEN_W-1 bytes).
- REQ-005 CLOCK  in  1  system clock; all logic on its rising edge.
- REQ-006 RESET  in  1  reset, asynchronous and active-high.
- REQ-007 RTC_NRST  out  1  DS1302 CE; high for the duration of a transfer.
- REQ-008 RTC_SCLK  out  1  serial clock; idles low.
- REQ-009 RTC_DATA  inout  1  serial data, LSB first; high-Z whenever the module is not driving it.
- REQ-010 iCall  in  2  request: bit1 = write, bit0 = read.
- REQ-011 iAddr  in  8  command byte; bit7 is forced to 1; bit0 is forced to 0 for write and 1 for read.
- REQ-012 iLen  in  LEN_W  data byte count; 0 is treated as 1.
- REQ-013 iData  in  8  write byte, captured on each oNext cycle.
- REQ-014 oNext  out  1  one-cycle pulse marking iData capture.
- REQ-015 oData  out  8  last received read byte.
- REQ-016 oValid  out  1  one-cycle pulse when oData updates.
- REQ-017 oBusy  out  1  high from the acceptance cycle until the oDone cycle inclusive.
- REQ-018 oDone  out  1  one-cycle pulse at end of transfer.

Function
- REQ-019 The FSM SHALL have states IDLE, SETUP, CMD, WDATA, RDATA, HOLD and DONE.
- REQ-020 In IDLE, a nonzero iCall SHALL be accepted (cycle 0), latching iAddr, iLen and the direction; iCall=2'b11 SHALL be accepted as a write.
- REQ-021 A nonzero iCall while oBusy is high SHALL be ignored.
- REQ-022 RTC_NRST SHALL rise at cycle 1 and hold in SETUP for CE_SETUP cycles.
- REQ-023 Each bit SHALL be a low half followed by a high half of CLK_DIV cycles each; driven data SHALL change only at the start of the low half.
- REQ-024 CMD SHALL shift out 8 command bits, LSB first.
- REQ-025 WDATA SHALL capture iData with an oNext pulse in the first cycle of each data byte, then shift out 8 bits.
- REQ-026 RDATA SHALL release RTC_DATA from the first cycle after the 8th command bit's high half ends.
- REQ-027 RDATA SHALL sample RTC_DATA in the last cycle of each low half, LSB first.
- REQ-028 After each 8th read bit, RDATA SHALL update oData and pulse oValid in the next cycle.
- REQ-029 After the last data byte, HOLD SHALL keep RTC_SCLK low for CE_HOLD cycles, then drop RTC_NRST.
- REQ-030 DONE SHALL pulse oDone for one cycle with RTC_NRST low, then return to IDLE.
- REQ-031 The oDone pulse SHALL occur at cycle 1 + CE_SETUP + (8 + 8·N)·2·CLK_DIV + CE_HOLD, where N is the effective length.
- REQ-032 Byte and bit counters SHALL be sized from LEN_W and SHALL NOT wrap within a transfer.

Reset
- REQ-033 RESET high SHALL immediately force IDLE, with RTC_NRST=0, RTC_SCLK=0, RTC_DATA high-Z, oData=8'h00 and oNext=oValid=oDone=oBusy=0.
- REQ-034 A reset mid-transfer SHALL abort the transfer with no oDone and no oValid.

Configuration
- REQ-035 With macro DS1302_BURST_EN defined, iLen SHALL be honoured as in REQ-012.
- REQ-036 Without DS1302_BURST_EN, iLen SHALL be ignored, N SHALL be fixed at 1, and the byte counter SHALL be removed.

Verification (CLK_DIV=4, CE_SETUP=8, CE_HOLD=8, DS1302_BURST_EN defined)
- REQ-037 Write test: iCall=2'b10, iAddr=8'h80, iData=8'h59, iLen=1 -> model receives 0x80 then 0x59, one oNext, oDone at cycle 145.
- REQ-038 Read test: iCall=2'b01, iAddr=8'h80 with the model returning 0x23 -> command seen as 0x81, RTC_DATA high-Z during data, oValid with oData=8'h23, oDone at cycle 145.
- REQ-039 Burst write test: iAddr=8'hBE, iLen=8 -> 8 oNext pulses spaced 64 cycles apart, model receives 8 bytes in order, oDone at cycle 593.
- REQ-040 Burst read test: iAddr=8'hBF, iLen=3 with model bytes 0x11/0x22/0x33 -> three oValid pulses carrying those values in order, oDone at cycle 273.
- REQ-041 Reset test: RESET asserted at cycle 60 of a write -> RTC_NRST=0 and RTC_DATA high-Z in the same cycle, no oDone; a new call after release completes normally.
- REQ-042 Busy and priority test: iCall=2'b11 -> write performed; a second iCall during oBusy is ignored, and exactly one oDone is seen.
